cv32e40p_trace_buffer: RTL and testbench
========================================

Name: cv32e40p_trace_buffer

Overview:
- Parametrised multi-hart retired-instruction trace capture buffer.
- Sits beside one or more cv32e40p_core instances in the core wrapper level and records {hart, pc, instr} retire events in a circular buffer.
- Adds trigger-armed start, stop-on-full or wrap-overwrite modes, and drop/overflow accounting.
- Buffer drains through a valid/ready port to a debug or UART sink.

Parameters:
- NUM_HARTS, 1, number of traced cores (1..8).
- DEPTH, 16, buffer entries; power of 2, at least 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  capture enable (level).
- clear_i  in  1  synchronous clear of buffer, counters and flags.
- mode_wrap_i  in  1  1 = overwrite oldest when full; 0 = stop when full.
- trig_en_i  in  1  1 = capture waits for a PC trigger.
- trig_pc_i  in  32  trigger PC.
- trace_valid_i  in  NUM_HARTS  per-hart retire strobe.
- trace_pc_i  in  NUM_HARTS x 32  per-hart retired PC.
- trace_instr_i  in  NUM_HARTS x 32  per-hart retired instruction.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  sink accepts head entry.
- out_hart_o  out  max(1,$clog2(NUM_HARTS))  head hart index.
- out_pc_o  out  32  head PC.
- out_instr_o  out  32  head instruction.
- count_o  out  $clog2(DEPTH)+1  entries held.
- state_o  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN.
- overflow_o  out  1  sticky; an event was lost or overwritten due to full.
- drop_cnt_o  out  DROP_CNT_W  saturating count of lost events.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; head, tail and count 0; out_valid_o 0; overflow_o 0; drop_cnt_o 0. Buffer storage is not reset. Reset asserted mid-capture discards all contents.
- clear_i has the same effect as reset, synchronously. It overrides all other same-cycle events. Next state is IDLE.
- FSM transitions:
  - IDLE -> (enable_i & trig_en_i) ARMED; (enable_i & !trig_en_i) CAPTURE.
  - ARMED -> CAPTURE on the first cycle where the selected event's pc == trig_pc_i. That trigger event is itself stored.
  - CAPTURE -> FROZEN when the buffer is full in stop mode and an event is lost.
  - FROZEN is left only by clear_i or reset. The buffer stays drainable in FROZEN.
  - Any state except FROZEN -> IDLE when enable_i=0. Contents are retained and drainable in IDLE.
- Event selection:
  - Per cycle, the lowest-index hart with trace_valid_i=1 is selected.
  - In CAPTURE, each other valid hart that cycle counts as a lost event: drop_cnt += popcount(trace_valid_i)-1, saturating at all-ones. overflow_o is not set by this.
  - No drops are counted in IDLE or ARMED.
- Push/pop:
  - Push when in CAPTURE (or on the trigger cycle from ARMED) and the selected event exists.
  - Pop when out_valid_o & out_ready_i.
  - out_valid_o = (count != 0). Outputs come combinationally from the head entry.
  - Latency: an event pushed into an empty buffer in cycle N has out_valid_o=1 in cycle N+1.
- Full-buffer rules (count == DEPTH):
  - Push and pop in the same cycle: both happen, count unchanged, in either mode.
  - Wrap mode, push without pop: oldest entry overwritten, head and tail advance, count stays DEPTH, overflow_o set, drop_cnt += 1.
  - Stop mode, push without pop: event discarded, drop_cnt += 1, overflow_o set, state -> FROZEN.
- Empty buffer: pop is impossible because out_valid_o=0; out_ready_i is ignored.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.

Test Plan:
- DEPTH=4, NUM_HARTS=1, stop mode, no trigger; push pc 0x100,0x104,0x108,0x10C,0x110 with out_ready_i=0 -> count_o=4, state FROZEN, drop_cnt_o=1, overflow_o=1; drain yields 0x100..0x10C in order, then out_valid_o=0.
- Same setup, wrap mode -> after 5 pushes count_o=4, drain yields 0x104,0x108,0x10C,0x110, overflow_o=1, state CAPTURE.
- trig_en_i=1, trig_pc_i=0x200; events 0x1F8,0x1FC,0x200,0x204 -> state ARMED until the 0x200 cycle; buffer holds exactly 0x200,0x204; drop_cnt_o=0.
- NUM_HARTS=2; both harts valid for 3 cycles (hart0 pc 0x0/0x4/0x8, hart1 pc 0x1000...) -> only hart0 entries stored with out_hart_o=0, drop_cnt_o=3.
- Full buffer in stop mode with simultaneous push and pop each cycle for 10 cycles -> count_o stays 4, no drops, FIFO order preserved.
- Assert rst_ni low for 1 cycle mid-capture with count 3 -> immediately out_valid_o=0, count_o=0, state IDLE; after release with enable_i=1, capture restarts from an empty buffer.

Source files
------------

// File: rtl/cv32e40p_trace_buffer.sv
// cv32e40p_trace_buffer
//   Multi-hart retired-instruction trace capture buffer. Each cycle the
//   lowest-index hart with a retire strobe is selected and its {hart, pc,
//   instr} is pushed into a circular buffer while capturing. Capture can be
//   armed on a PC trigger; a full buffer either overwrites the oldest entry
//   (wrap mode) or freezes capture (stop mode). Lost events are counted in a
//   saturating drop counter.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enable_i               capture enable (level)
//   clear_i                synchronous clear of buffer, counters, flags, FSM
//   mode_wrap_i            1 = overwrite oldest when full, 0 = freeze when full
//   trig_en_i, trig_pc_i   PC trigger arm and match value
//   trace_valid_i/pc/instr per-hart retire strobes and payload
//   out_valid_o/out_ready_i head-entry drain handshake
//   out_hart_o/pc/instr    head entry payload (combinational from storage)
//   count_o                entries held
//   state_o                FSM state (0 IDLE, 1 ARMED, 2 CAPTURE, 3 FROZEN)
//   overflow_o             sticky: an event was lost/overwritten due to full
//   drop_cnt_o             saturating count of lost events
//
// Handshake: the head entry transfers on every cycle where out_valid_o and
// out_ready_i are both high; out_valid_o never depends on out_ready_i, and
// out_ready_i is ignored while the buffer is empty.
module cv32e40p_trace_buffer #(
  parameter int unsigned NUM_HARTS  = 1,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DROP_CNT_W = 16,
  localparam int unsigned HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic                           mode_wrap_i,
  input  logic                           trig_en_i,
  input  logic [31:0]                    trig_pc_i,
  input  logic [NUM_HARTS-1:0]           trace_valid_i,
  input  logic [NUM_HARTS-1:0][31:0]     trace_pc_i,
  input  logic [NUM_HARTS-1:0][31:0]     trace_instr_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [HART_W-1:0]              out_hart_o,
  output logic [31:0]                    out_pc_o,
  output logic [31:0]                    out_instr_o,
  output logic [CNT_W-1:0]               count_o,
  output logic [1:0]                     state_o,
  output logic                           overflow_o,
  output logic [DROP_CNT_W-1:0]          drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        head_q, tail_q;
  logic [CNT_W-1:0]        count_q;
  logic                    overflow_q;
  logic [DROP_CNT_W-1:0]   drop_q;

  logic [HART_W-1:0]       mem_hart  [DEPTH];
  logic [31:0]             mem_pc    [DEPTH];
  logic [31:0]             mem_instr [DEPTH];

  // Event selection
  logic                    sel_valid;
  logic [HART_W-1:0]       sel_hart;
  logic [31:0]             sel_pc;
  logic [31:0]             sel_instr;
  logic [3:0]              n_valid;

  always_comb begin
    sel_valid = 1'b0;
    sel_hart  = '0;
    sel_pc    = '0;
    sel_instr = '0;
    n_valid   = '0;
    // Walk downward so the lowest-index valid hart is the last to win.
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (trace_valid_i[i]) begin
        sel_valid = 1'b1;
        sel_hart  = HART_W'(i);
        sel_pc    = trace_pc_i[i];
        sel_instr = trace_instr_i[i];
        n_valid   = n_valid + 4'd1;
      end
    end
  end

  // Buffer control
  logic trig_hit, cap_active, push_req, pop, full;
  logic lost_full, do_write, wrap_over, head_adv;
  logic [3:0] drop_add;
  logic [DROP_CNT_W+3:0] drop_sum;

  always_comb begin
    trig_hit   = sel_valid && (sel_pc == trig_pc_i);
    // The trigger event itself is captured in the ARMED cycle that matches.
    cap_active = (state_q == ST_CAPTURE) || ((state_q == ST_ARMED) && trig_hit);
    push_req   = cap_active && sel_valid;
    pop        = (count_q != '0) && out_ready_i;
    full       = (count_q == CNT_W'(DEPTH));
    lost_full  = push_req && full && !pop;
    do_write   = push_req && (!full || pop || mode_wrap_i);
    // Wrap overwrite consumes the oldest slot, so head moves with tail.
    wrap_over  = lost_full && mode_wrap_i;
    head_adv   = pop || wrap_over;

    drop_add = {3'b000, lost_full};
    if ((state_q == ST_CAPTURE) && sel_valid)
      drop_add = drop_add + (n_valid - 4'd1);
    drop_sum = {4'b0000, drop_q} + {{DROP_CNT_W{1'b0}}, drop_add};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = trig_en_i ? ST_ARMED : ST_CAPTURE;
      end
      ST_ARMED: begin
        if (!enable_i)                       state_d = ST_IDLE;
        else if (lost_full && !mode_wrap_i)  state_d = ST_FROZEN;
        else if (trig_hit)                   state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // A stop-mode loss freezes even if enable drops in the same cycle.
        if (lost_full && !mode_wrap_i) state_d = ST_FROZEN;
        else if (!enable_i)            state_d = ST_IDLE;
      end
      ST_FROZEN: state_d = ST_FROZEN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clear_i) begin
      state_q    <= ST_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (do_write) tail_q <= tail_q + 1'b1;
      if (head_adv) head_q <= head_q + 1'b1;
      if (do_write && !head_adv)      count_q <= count_q + 1'b1;
      else if (head_adv && !do_write) count_q <= count_q - 1'b1;
      if (lost_full) overflow_q <= 1'b1;
      if (|drop_sum[DROP_CNT_W+3:DROP_CNT_W]) drop_q <= '1;
      else                                     drop_q <= drop_sum[DROP_CNT_W-1:0];
    end
  end

  // Storage is not reset; only entries below count are ever observable.
  always_ff @(posedge clk_i) begin
    if (do_write && !clear_i) begin
      mem_hart[tail_q]  <= sel_hart;
      mem_pc[tail_q]    <= sel_pc;
      mem_instr[tail_q] <= sel_instr;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign out_hart_o  = mem_hart[head_q];
  assign out_pc_o    = mem_pc[head_q];
  assign out_instr_o = mem_instr[head_q];
  assign count_o     = count_q;
  assign state_o     = state_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Testbench for cv32e40p_trace_buffer (NUM_HARTS=2, DEPTH=4, DROP_CNT_W=4).
module tb_cv32e40p_trace_buffer;

  localparam int NH = 2;
  localparam int D  = 4;
  localparam int DW = 4;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_FROZEN = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                enable, clear, mode_wrap, trig_en, out_ready;
  logic [31:0]         trig_pc;
  logic [NH-1:0]       tv;
  logic [NH-1:0][31:0] tpc;
  logic [NH-1:0][31:0] tinstr;
  logic                out_valid, overflow;
  logic [0:0]          out_hart;
  logic [31:0]         out_pc, out_instr;
  logic [2:0]          count;
  logic [1:0]          state;
  logic [DW-1:0]       drop_cnt;

  cv32e40p_trace_buffer #(.NUM_HARTS(NH), .DEPTH(D), .DROP_CNT_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .mode_wrap_i(mode_wrap), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
    .trace_valid_i(tv), .trace_pc_i(tpc), .trace_instr_i(tinstr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_hart_o(out_hart),
    .out_pc_o(out_pc), .out_instr_o(out_instr), .count_o(count),
    .state_o(state), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  // Scoreboard: expected buffer contents {hart, pc, instr}, oldest first
  logic [64:0] exp_q[$];
  int  m_state;
  int  m_drop;
  bit  m_ovf;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = S_IDLE;
    m_drop  = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_outputs();
    check("count", 64'(count), 64'(exp_q.size()));
    check("state", 64'(state), 64'(m_state));
    check("valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (exp_q.size() != 0) begin
      check("out_hart", 64'(out_hart), 64'(exp_q[0][64]));
      check("out_pc", 64'(out_pc), 64'(exp_q[0][63:32]));
      check("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
    end
  endtask

  // Reference model: one clock of behaviour from the current inputs.
  task automatic model_update();
    int sel, nv, add, nxt;
    bit pop, full, hit, capt, lost;
    logic [64:0] e;
    if (clear) begin
      model_reset();
      return;
    end
    sel = -1;
    nv  = 0;
    for (int i = 0; i < NH; i++)
      if (tv[i]) begin
        nv++;
        if (sel < 0) sel = i;
      end
    pop  = (exp_q.size() > 0) && out_ready;
    full = (exp_q.size() == D);
    hit  = (sel >= 0) && (tpc[sel] == trig_pc);
    capt = (m_state == S_CAPTURE) || (m_state == S_ARMED && hit);
    lost = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (capt && sel >= 0) begin
      e = {1'(sel), tpc[sel], tinstr[sel]};
      if (full && !pop) begin
        lost = 1'b1;
        if (mode_wrap) begin
          void'(exp_q.pop_front());
          exp_q.push_back(e);
        end
      end else begin
        exp_q.push_back(e);
      end
    end
    add = int'(lost);
    if (m_state == S_CAPTURE && nv > 1) add += nv - 1;
    m_drop = (m_drop + add > (1 << DW) - 1) ? (1 << DW) - 1 : m_drop + add;
    if (lost) m_ovf = 1'b1;
    nxt = m_state;
    case (m_state)
      S_IDLE:    if (enable) nxt = trig_en ? S_ARMED : S_CAPTURE;
      S_ARMED:   if (!enable) nxt = S_IDLE;
                 else if (lost && !mode_wrap) nxt = S_FROZEN;
                 else if (hit) nxt = S_CAPTURE;
      S_CAPTURE: if (lost && !mode_wrap) nxt = S_FROZEN;
                 else if (!enable) nxt = S_IDLE;
      default:   nxt = m_state;
    endcase
    m_state = nxt;
  endtask

  // Driver tasks
  task automatic set_ev(input bit v0, input logic [31:0] p0, input bit v1, input logic [31:0] p1);
    tv        = {v1, v0};
    tpc[0]    = p0;
    tpc[1]    = p1;
    tinstr[0] = p0 ^ 32'h1357_9BDF;
    tinstr[1] = p1 ^ 32'h2468_ACE0;
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    set_ev(0, 0, 0, 0);
    step();
    clear = 1'b0;
  endtask

  initial begin
    enable = 0; clear = 0; mode_wrap = 0; trig_en = 0; trig_pc = 0; out_ready = 0;
    set_ev(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Stop mode, no trigger: fifth push is lost and freezes capture
    do_clear();
    enable = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      set_ev(1, 32'h100 + 32'(4 * i), 0, 0);
      step();
    end
    set_ev(0, 0, 0, 0);
    check("t1_count", 64'(count), 64'd4);
    check("t1_state", 64'(state), 64'(S_FROZEN));
    check("t1_drop", 64'(drop_cnt), 64'd1);
    check("t1_ovf", 64'(overflow), 64'd1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t1_drain", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
      step();
    end
    check("t1_empty", 64'(out_valid), 64'd0);
    out_ready = 0;

    // Wrap mode: oldest entry overwritten
    do_clear();
    mode_wrap = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      set_ev(1, 32'h100 + 32'(4 * i), 0, 0);
      step();
    end
    set_ev(0, 0, 0, 0);
    check("t2_count", 64'(count), 64'd4);
    check("t2_state", 64'(state), 64'(S_CAPTURE));
    check("t2_ovf", 64'(overflow), 64'd1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain", 64'(out_pc), 64'(32'h104 + 32'(4 * i)));
      step();
    end
    check("t2_empty", 64'(out_valid), 64'd0);
    out_ready = 0;
    mode_wrap = 0;

    // PC trigger: capture starts with the matching event
    do_clear();
    trig_en = 1;
    trig_pc = 32'h200;
    step();
    for (int i = 0; i < 4; i++) begin
      set_ev(1, 32'h1F8 + 32'(4 * i), 0, 0);
      check("t3_state", 64'(state), 64'(i <= 2 ? S_ARMED : S_CAPTURE));
      step();
    end
    set_ev(0, 0, 0, 0);
    check("t3_count", 64'(count), 64'd2);
    check("t3_head", 64'(out_pc), 64'h200);
    check("t3_drop", 64'(drop_cnt), 64'd0);
    trig_en = 0;

    // Two harts valid together: hart0 stored, hart1 dropped
    do_clear();
    step();
    for (int i = 0; i < 3; i++) begin
      set_ev(1, 32'(4 * i), 1, 32'h1000 + 32'(4 * i));
      step();
    end
    set_ev(0, 0, 0, 0);
    check("t4_count", 64'(count), 64'd3);
    check("t4_hart", 64'(out_hart), 64'd0);
    check("t4_drop", 64'(drop_cnt), 64'd3);
    check("t4_ovf", 64'(overflow), 64'd0);

    // Full buffer, stop mode, push and pop every cycle
    do_clear();
    step();
    for (int i = 0; i < 4; i++) begin
      set_ev(1, 32'h300 + 32'(4 * i), 0, 0);
      step();
    end
    out_ready = 1;
    for (int i = 4; i < 14; i++) begin
      set_ev(1, 32'h300 + 32'(4 * i), 0, 0);
      check("t5_head", 64'(out_pc), 64'(32'h300 + 32'(4 * (i - 4))));
      step();
      check("t5_count", 64'(count), 64'd4);
    end
    set_ev(0, 0, 0, 0);
    out_ready = 0;
    check("t5_drop", 64'(drop_cnt), 64'd0);
    check("t5_state", 64'(state), 64'(S_CAPTURE));

    // Asynchronous reset mid-capture
    do_clear();
    step();
    for (int i = 0; i < 3; i++) begin
      set_ev(1, 32'h380 + 32'(4 * i), 0, 0);
      step();
    end
    set_ev(0, 0, 0, 0);
    check("t6_pre", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_state", 64'(state), 64'(S_IDLE));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    set_ev(1, 32'h400, 0, 0);
    step();
    set_ev(0, 0, 0, 0);
    check("t6_restart_count", 64'(count), 64'd1);
    check("t6_restart_pc", 64'(out_pc), 64'h400);

    // Randomized stimulus against the reference model
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      clear     = ($urandom_range(0, 79) == 0);
      enable    = ($urandom_range(0, 15) != 0);
      mode_wrap = ($urandom_range(0, 1) == 1);
      trig_en   = ($urandom_range(0, 2) == 0);
      trig_pc   = 32'h40;
      out_ready = ($urandom_range(0, 2) == 0);
      set_ev($urandom_range(0, 1) == 1, 32'(4 * $urandom_range(0, 31)),
             $urandom_range(0, 1) == 1, 32'(4 * $urandom_range(0, 31)));
      step();
    end
    clear = 0;
    set_ev(0, 0, 0, 0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
